// File: rtl/program_counter.sv
// program_counter: 16-bit PC stage for the mos6502 core.
//   Updates pc each clock from the ps control word (HOLD/INC/REL/ABS).
//   Builds absolute jump targets from a latched low byte plus the current bus
//   byte. Drives the memory address bus through the PC/address-register mux.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       synchronous, active-high reset
//   ps[1:0]     PC control: 0 HOLD, 1 INC, 2 REL, 3 ABS
//   mm          address mux select: 0 PC_ADDR, 1 A_ADDR
//   lo_ld       latch data_in as low byte of the absolute target
//   data_in     memory read data (relative offset or target byte)
//   addr_reg    address-register value from the datapath
//   pc          current program counter (registered)
//   addr        memory address bus (combinational)
//   page_cross  branch page-cross flag (registered when enabled)
//
// Optional feature macro: PC_PAGECROSS_EN
//   defined   -> page_cross is set on a REL update that changes the high
//                byte relative to pc+1, cleared on every other edge
//   undefined -> page_cross is tied to 0 and no flop is built
module program_counter #(
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ps,
  input  logic        mm,
  input  logic        lo_ld,
  input  logic [7:0]  data_in,
  input  logic [15:0] addr_reg,
  output logic [15:0] pc,
  output logic [15:0] addr,
  output logic        page_cross
);

  localparam logic [1:0] PS_HOLD = 2'd0;
  localparam logic [1:0] PS_INC  = 2'd1;
  localparam logic [1:0] PS_REL  = 2'd2;
  localparam logic [1:0] PS_ABS  = 2'd3;

  localparam logic MM_PC_ADDR = 1'b0;

  logic [7:0]  lo_q;
  logic [15:0] pc_inc;
  logic [15:0] pc_rel;
  logic [15:0] pc_next;

  // Offset is relative to the byte after the offset operand.
  assign pc_inc = pc + 16'd1;
  assign pc_rel = pc_inc + {{8{data_in[7]}}, data_in};

  // Next-pc selection.
  always_comb begin
    pc_next = pc;
    case (ps)
      PS_HOLD: pc_next = pc;
      PS_INC:  pc_next = pc_inc;
      PS_REL:  pc_next = pc_rel;
      PS_ABS:  pc_next = {data_in, lo_q};
      default: pc_next = pc;
    endcase
  end

  // PC and low-byte latch; ABS reads the old lo_q even when lo_ld fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc   <= RESET_VEC;
      lo_q <= 8'h00;
    end else begin
      pc <= pc_next;
      if (lo_ld) begin
        lo_q <= data_in;
      end
    end
  end

`ifdef PC_PAGECROSS_EN
  // Flag a taken branch that lands on a different page than pc+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      page_cross <= 1'b0;
    end else begin
      page_cross <= (ps == PS_REL) && (pc_rel[15:8] != pc_inc[15:8]);
    end
  end
`else
  assign page_cross = 1'b0;
`endif

  // Zero-latency address mux.
  assign addr = (mm == MM_PC_ADDR) ? pc : addr_reg;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  localparam logic [15:0] RV = 16'hC000;

  logic        clk;
  logic        reset;
  logic [1:0]  ps;
  logic        mm;
  logic        lo_ld;
  logic [7:0]  data_in;
  logic [15:0] addr_reg;
  logic [15:0] pc;
  logic [15:0] addr;
  logic        page_cross;

  int n_vec;
  int n_bad;

  // Reference state
  logic [15:0] m_pc;
  logic [7:0]  m_lo;
  logic        m_pcx;

  program_counter #(.RESET_VEC(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps         (ps),
    .mm         (mm),
    .lo_ld      (lo_ld),
    .data_in    (data_in),
    .addr_reg   (addr_reg),
    .pc         (pc),
    .addr       (addr),
    .page_cross (page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, using plain integer arithmetic.
  task automatic model_edge(input logic r, input logic [1:0] p, input logic l, input logic [7:0] d);
    int off;
    int nxt;
    if (r) begin
      m_pc  = RV;
      m_lo  = 8'h00;
      m_pcx = 1'b0;
    end else begin
      m_pcx = 1'b0;
      case (p)
        2'd1: m_pc = 16'((int'(m_pc) + 1) % 65536);
        2'd2: begin
          off = (d >= 8'd128) ? int'(d) - 256 : int'(d);
          nxt = (int'(m_pc) + 1 + off + 65536) % 65536;
          m_pcx = ((nxt / 256) != (((int'(m_pc) + 1) % 65536) / 256));
          m_pc = 16'(nxt);
        end
        2'd3: m_pc = 16'(int'(d) * 256 + int'(m_lo));
        default: ;
      endcase
      if (l) m_lo = d;
    end
  endtask

  function automatic logic exp_pcx();
`ifdef PC_PAGECROSS_EN
    return m_pcx;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input string tag, input logic r, input logic [1:0] p, input logic m,
                      input logic l, input logic [7:0] d, input logic [15:0] ar);
    reset = r; ps = p; mm = m; lo_ld = l; data_in = d; addr_reg = ar;
    @(posedge clk);
    model_edge(r, p, l, d);
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".addr"}, addr, m ? ar : m_pc);
    check({tag, ".pcx"}, {15'd0, page_cross}, {15'd0, exp_pcx()});
  endtask

  // Two-cycle absolute load of an arbitrary pc value.
  task automatic load_pc(input logic [15:0] v);
    step("ld_lo", 1'b0, 2'd0, 1'b0, 1'b1, v[7:0], 16'h0);
    step("ld_abs", 1'b0, 2'd3, 1'b0, 1'b0, v[15:8], 16'h0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    m_pc = '0; m_lo = '0; m_pcx = 1'b0;
    reset = 1'b1; ps = 2'd1; mm = 1'b0; lo_ld = 1'b0; data_in = 8'h00; addr_reg = 16'h0;

    // 1. Reset with INC held, then three INCs
    step("rst0", 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 16'h0);
    step("rst1", 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 16'h0);
    check("rst_pc", pc, 16'hC000);
    check("rst_addr", addr, 16'hC000);
    check("rst_pcx", {15'd0, page_cross}, 16'h0);
    for (int i = 0; i < 3; i++) step("inc", 1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 16'h0);
    check("inc3", pc, 16'hC003);

    // 2. Wrap and hold
    load_pc(16'hFFFF);
    step("wrap", 1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 16'h0);
    check("wrap_pc", pc, 16'h0000);
    for (int i = 0; i < 4; i++) step("hold", 1'b0, 2'd0, 1'b0, 1'b0, 8'h55, 16'h0);
    check("hold_pc", pc, 16'h0000);

    // 3. Relative branches
    load_pc(16'h1010);
    step("rel_fwd", 1'b0, 2'd2, 1'b0, 1'b0, 8'h05, 16'h0);
    check("rel_fwd_pc", pc, 16'h1016);
    load_pc(16'h1010);
    step("rel_bwd", 1'b0, 2'd2, 1'b0, 1'b0, 8'hF0, 16'h0);
    check("rel_bwd_pc", pc, 16'h1001);
    load_pc(16'h1080);
    step("rel_x", 1'b0, 2'd2, 1'b0, 1'b0, 8'h7F, 16'h0);
    check("rel_x_pc", pc, 16'h1100);
`ifdef PC_PAGECROSS_EN
    check("rel_x_flag", {15'd0, page_cross}, 16'h1);
`else
    check("rel_x_flag", {15'd0, page_cross}, 16'h0);
`endif
    load_pc(16'h1000);
    step("rel_m128", 1'b0, 2'd2, 1'b0, 1'b0, 8'h80, 16'h0);
    check("rel_m128_pc", pc, 16'h0F81);

    // 4. Two-byte jump, then lo_ld coincident with ABS
    step("j_lo", 1'b0, 2'd1, 1'b0, 1'b1, 8'h34, 16'h0);
    step("j_abs", 1'b0, 2'd3, 1'b0, 1'b0, 8'h12, 16'h0);
    check("jmp_pc", pc, 16'h1234);
    step("j_same", 1'b0, 2'd3, 1'b0, 1'b1, 8'hAB, 16'h0);
    check("same_pc", pc, 16'hAB34);
    step("j_after", 1'b0, 2'd3, 1'b0, 1'b0, 8'hCD, 16'h0);
    check("lo_after", pc, 16'hCDAB);

    // 5. Address mux with no clock edge
    load_pc(16'h0200);
    mm = 1'b1; addr_reg = 16'h00FF; #1;
    check("mux_a", addr, 16'h00FF);
    mm = 1'b0; #1;
    check("mux_pc", addr, 16'h0200);

    // 6. Mid-sequence reset clears the latched low byte
    step("mr_lo", 1'b0, 2'd0, 1'b0, 1'b1, 8'h77, 16'h0);
    step("mr_rst", 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 16'h0);
    step("mr_abs", 1'b0, 2'd3, 1'b0, 1'b0, 8'h12, 16'h0);
    check("mr_pc", pc, 16'h1200);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter stage for the mos6502 core. Consumes the ps_t control word (HOLD/INC/REL/ABS) and the mm_t address-select from the control unit.
- Assembles absolute jump targets from two bytes fetched from memory on consecutive cycles.
- Drives the memory address bus through the PC/address-register mux.
- Sits between the control FSM (upstream, produces ps/mm) and the memory (downstream, consumes addr).

Parameters:
- RESET_VEC, 16'h0000, value loaded into pc on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ps  input  2  PC control, ps_t encoding: 0 HOLD, 1 INC, 2 REL, 3 ABS.
- mm  input  1  memory mux select, mm_t encoding: 0 PC_ADDR, 1 A_ADDR.
- lo_ld  input  1  latch data_in as the low byte of the absolute target.
- data_in  input  8  memory read data; supplies relative offset or target bytes.
- addr_reg  input  16  address-register value from the datapath.
- pc  output  16  current program counter (registered).
- addr  output  16  memory address bus (combinational).
- page_cross  output  1  branch page-cross flag (see Optional Feature).

Behaviour:
Clock and reset:
- Single clock domain; reset is synchronous and active-high.
- Reset dominates all other inputs in the same cycle.
- Reset values: pc=RESET_VEC, internal lo_q=8'h00, page_cross=0.
- addr is combinational, so it follows the reset pc and mm in the cycle after the reset edge.
- Reset asserted mid-sequence (lo_q latched, ABS not yet issued) discards the partial target. A later ABS without a fresh lo_ld uses lo_q=00.

PC update, next-state on each rising edge when reset=0:
- HOLD: pc unchanged.
- INC: pc <= pc + 1, modulo 2^16 (FFFF -> 0000, no flag).
- REL: pc <= pc + 1 + sext16(data_in), modulo 2^16.
  - pc points at the offset byte, so the offset is relative to the following instruction.
  - data_in 80 = -128; data_in 7F = +127.
- ABS: pc <= {data_in, lo_q}, i.e. high byte from the current bus, low byte from the earlier latch.

lo_q latch:
- lo_ld=1 sets lo_q <= data_in, independent of ps.
- lo_ld=1 in the same cycle as ABS: ABS uses the OLD lo_q, and lo_q then takes data_in.
- lo_q holds its value otherwise.

Address mux:
- addr = (mm==PC_ADDR) ? pc : addr_reg.
- Zero latency; no registered path.

Timing and encodings:
- Latency of ps to a visible pc change is one clock.
- There is no back-pressure; ps is sampled every cycle.
- All ps encodings are defined, so there are no illegal states.

Optional Feature:
Macro PC_PAGECROSS_EN.
- Defined:
  - page_cross is registered.
  - It is set to 1 on the edge where a REL update produces pc_new[15:8] != (pc+1)[15:8].
  - It is set to 0 on every other edge, including REL without a crossing, HOLD, INC and ABS.
  - Reset clears it.
  - The control FSM uses it to insert the extra branch cycle.
- Undefined:
  - page_cross is tied to constant 0.
  - The port remains present so the interface is identical in both builds.
  - No extra flops are inferred.

Test Plan:
1. Reset with RESET_VEC=16'hC000, ps=INC held during reset -> pc=C000, addr=C000 (mm=0), page_cross=0. After reset release, 3 INC cycles -> pc=C003.
2. pc=FFFF, ps=INC -> pc=0000. Then ps=HOLD for 4 cycles -> pc stays 0000.
3. pc=1010, ps=REL:
   - data_in=05 -> pc=1016.
   - From pc=1010, data_in=F0 (-16) -> pc=1001.
   - From pc=1080, data_in=7F -> pc=1100, page_cross=1 with PC_PAGECROSS_EN, 0 without.
4. Two-byte jump:
   - lo_ld=1, data_in=34 (ps=INC), then ps=ABS, data_in=12 -> pc=1234.
   - Same cycle lo_ld=1, data_in=AB with ABS -> pc={AB, old lo_q}; lo_q=AB afterwards.
5. Mux: pc=0200, addr_reg=00FF. mm=A_ADDR -> addr=00FF in the same cycle. mm=PC_ADDR -> addr=0200. No clock edge is needed.
6. Mid-sequence reset: lo_ld with data_in=77, then reset for one cycle, then ABS with data_in=12 -> pc=1200 (lo_q cleared).
